// File: rtl/avmm_io_pkg.sv
// Shared register-map constants and helpers for the Avalon-MM board I/O responder.
package avmm_io_pkg;

  localparam logic [2:0] ADDR_SW      = 3'd0;
  localparam logic [2:0] ADDR_KEY     = 3'd1;
  localparam logic [2:0] ADDR_EDGE    = 3'd2;
  localparam logic [2:0] ADDR_LEDR    = 3'd3;
  localparam logic [2:0] ADDR_HEX3_0  = 3'd4;
  localparam logic [2:0] ADDR_HEX5_4  = 3'd5;
  localparam logic [2:0] ADDR_IRQMASK = 3'd6;

  localparam logic [31:0] HEX_BLANK = 32'hFFFF_FFFF;

  // Bits needed to count 0..n-1; never less than one.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/avmm_io_responder_if.sv
// Avalon-MM slave-side bus bundle: fixed-latency reads, no waitrequest.
interface avmm_io_responder_if;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (output address, read, write, writedata,
                  input  readdata, readdatavalid);
  modport slave  (input  address, read, write, writedata,
                  output readdata, readdatavalid);
endinterface

// File: rtl/io_debounce.sv
// Per-bit 2-FF synchroniser followed by a stability counter; the output bit
// only follows the input once it has disagreed for DEBOUNCE_CYCLES cycles.
module io_debounce
  import avmm_io_pkg::*;
#(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] debounced
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CW-1:0]    cnt [WIDTH];

  // NOTE: every register here uses <= so all bits sample the pre-edge values
  // of their neighbours; blocking assignments would collapse the sync chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1     <= '0;
      sync2     <= '0;
      debounced <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == debounced[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          cnt[i]       <= '0;
          debounced[i] <= ~debounced[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/avmm_io_responder.sv
// Avalon-MM responder for switches, pushbuttons, LEDs and seven-segment displays.
// Optional button interrupt and IRQMASK register built when AVMM_IO_IRQ_EN is defined.
module avmm_io_responder
  import avmm_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int N_SW            = 10,
  parameter int N_KEY           = 4
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  avmm_io_responder_if.slave  avs,
  input  logic [N_SW-1:0]     sw_in,
  input  logic [N_KEY-1:0]    key_n_in,
  output logic [N_SW-1:0]     ledr_out,
  output logic [31:0]         hex3_hex0_out,
  output logic [15:0]         hex5_hex4_out,
  output logic                irq
);

  logic [N_SW-1:0]  sw_db;
  logic [N_KEY-1:0] key_db;
  logic [N_KEY-1:0] key_prev;
  logic [N_KEY-1:0] edge_q;
  logic [N_KEY-1:0] edge_set;
  logic [N_KEY-1:0] edge_clr;
  logic [N_KEY-1:0] mask_rd;
  logic [31:0]      rd_mux;

  io_debounce #(.WIDTH(N_SW), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .raw       (sw_in),
    .debounced (sw_db)
  );

  // Keys are inverted up front so every downstream bit means "pressed".
  io_debounce #(.WIDTH(N_KEY), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_db (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .raw       (~key_n_in),
    .debounced (key_db)
  );

  assign edge_set = key_db & ~key_prev;
  assign edge_clr = (avs.write && avs.address == ADDR_EDGE) ? avs.writedata[N_KEY-1:0] : '0;

  // NOTE: rd_mux is given a full default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    rd_mux = '0;
    unique case (avs.address)
      ADDR_SW:      rd_mux[N_SW-1:0]  = sw_db;
      ADDR_KEY:     rd_mux[N_KEY-1:0] = key_db;
      ADDR_EDGE:    rd_mux[N_KEY-1:0] = edge_q;
      ADDR_LEDR:    rd_mux[N_SW-1:0]  = ledr_out;
      ADDR_HEX3_0:  rd_mux            = hex3_hex0_out;
      ADDR_HEX5_4:  rd_mux[15:0]      = hex5_hex4_out;
      ADDR_IRQMASK: rd_mux[N_KEY-1:0] = mask_rd;
      default:      rd_mux            = '0;
    endcase
  end

  // The read mux samples pre-edge registers, so a simultaneous write is
  // performed while the read still returns the old value.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      key_prev          <= '0;
      edge_q            <= '0;
      ledr_out          <= '0;
      hex3_hex0_out     <= HEX_BLANK;
      hex5_hex4_out     <= HEX_BLANK[15:0];
      avs.readdatavalid <= 1'b0;
      avs.readdata      <= '0;
    end else begin
      key_prev          <= key_db;
      edge_q            <= (edge_q & ~edge_clr) | edge_set;
      avs.readdatavalid <= avs.read;
      if (avs.read) avs.readdata <= rd_mux;
      if (avs.write) begin
        case (avs.address)
          ADDR_LEDR:   ledr_out      <= avs.writedata[N_SW-1:0];
          ADDR_HEX3_0: hex3_hex0_out <= avs.writedata;
          ADDR_HEX5_4: hex5_hex4_out <= avs.writedata[15:0];
          default: ;
        endcase
      end
    end
  end

`ifdef AVMM_IO_IRQ_EN
  logic [N_KEY-1:0] irq_mask_q;
  logic             irq_q;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      irq_mask_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_q <= |(edge_q & irq_mask_q);
      if (avs.write && avs.address == ADDR_IRQMASK)
        irq_mask_q <= avs.writedata[N_KEY-1:0];
    end
  end

  assign mask_rd = irq_mask_q;
  assign irq     = irq_q;
`else
  assign mask_rd = '0;
  assign irq     = 1'b0;
`endif

endmodule

// File: tb/tb_avmm_io_responder.sv
// Directed bench for avmm_io_responder with DEBOUNCE_CYCLES=4.
module tb_avmm_io_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  sw_in;
  logic [3:0]  key_n_in;
  logic [9:0]  ledr_out;
  logic [31:0] hex3_hex0_out;
  logic [15:0] hex5_hex4_out;
  logic        irq;

  int n_vec  = 0;
  int n_miss = 0;

  avmm_io_responder_if avs ();

  avmm_io_responder #(.DEBOUNCE_CYCLES(4), .N_SW(10), .N_KEY(4)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .avs           (avs.slave),
    .sw_in         (sw_in),
    .key_n_in      (key_n_in),
    .ledr_out      (ledr_out),
    .hex3_hex0_out (hex3_hex0_out),
    .hex5_hex4_out (hex5_hex4_out),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output logic v);
    avs.address = a;
    avs.read    = 1'b1;
    tick();
    d = avs.readdata;
    v = avs.readdatavalid;
    avs.read = 1'b0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    avs.address   = a;
    avs.writedata = d;
    avs.write     = 1'b1;
    tick();
    avs.write = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        v;
    logic [31:0] exp_tab [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0000_FFFF};
    rst_n = 1'b0;
    avs.address = 3'd4;
    avs.read = 1'b1;
    repeat (3) tick();
    avs.read = 1'b0;
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (avs.readdatavalid !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_drop_read: readdatavalid=%b want 0", avs.readdatavalid);
    end
    n_vec++;
    if (ledr_out !== 10'h0 || hex3_hex0_out !== 32'hFFFF_FFFF || hex5_hex4_out !== 16'hFFFF || irq !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_pins: ledr=%h hex30=%h hex54=%h irq=%b want 000 ffffffff ffff 0",
               ledr_out, hex3_hex0_out, hex5_hex4_out, irq);
    end
    for (int i = 0; i < 6; i++) begin
      bus_read(3'(i), d, v);
      n_vec++;
      if (v !== 1'b1 || d !== exp_tab[i]) begin
        n_miss++;
        $display("FAIL reset_read[%0d]: valid=%b data=%h want 1 %h", i, v, d, exp_tab[i]);
      end
    end
    tick();
    n_vec++;
    if (avs.readdatavalid !== 1'b0) begin
      n_miss++;
      $display("FAIL valid_drops: readdatavalid=%b want 0", avs.readdatavalid);
    end
  endtask

  task automatic test_switches();
    logic [31:0] d;
    logic        v;
    sw_in = 10'h2A5;
    repeat (8) tick();
    bus_read(3'd0, d, v);
    n_vec++;
    if (d !== 32'h2A5) begin
      n_miss++;
      $display("FAIL sw_settle: data=%h want 000002a5", d);
    end
    sw_in = 10'h2A4;
    repeat (2) tick();
    sw_in = 10'h2A5;
    repeat (8) tick();
    bus_read(3'd0, d, v);
    n_vec++;
    if (d !== 32'h2A5) begin
      n_miss++;
      $display("FAIL sw_glitch: data=%h want 000002a5", d);
    end
    bus_write(3'd0, 32'h0);
    bus_read(3'd0, d, v);
    n_vec++;
    if (d !== 32'h2A5) begin
      n_miss++;
      $display("FAIL sw_ro_write: data=%h want 000002a5", d);
    end
  endtask

  task automatic test_key_edge();
    logic [31:0] d;
    logic        v;
    key_n_in = 4'b1011;
    repeat (8) tick();
    bus_read(3'd1, d, v);
    n_vec++;
    if (d !== 32'h4) begin
      n_miss++;
      $display("FAIL key_pressed: data=%h want 00000004", d);
    end
    bus_read(3'd2, d, v);
    n_vec++;
    if (d !== 32'h4) begin
      n_miss++;
      $display("FAIL edge_set: data=%h want 00000004", d);
    end
    bus_write(3'd2, 32'h4);
    bus_read(3'd2, d, v);
    n_vec++;
    if (d !== 32'h0) begin
      n_miss++;
      $display("FAIL edge_clear: data=%h want 00000000", d);
    end
    key_n_in = 4'hF;
    repeat (8) tick();
    bus_read(3'd1, d, v);
    n_vec++;
    if (d !== 32'h0) begin
      n_miss++;
      $display("FAIL key_release: data=%h want 00000000", d);
    end
    bus_read(3'd2, d, v);
    n_vec++;
    if (d !== 32'h0) begin
      n_miss++;
      $display("FAIL edge_no_release: data=%h want 00000000", d);
    end
  endtask

  // Press reaches the debounced output on the 6th edge after the pin drops;
  // the 7th edge is the one where EDGE[0] sets, so the clear lands there.
  task automatic test_edge_race();
    logic [31:0] d;
    logic        v;
    key_n_in = 4'b1110;
    repeat (6) tick();
    bus_write(3'd2, 32'h1);
    bus_read(3'd2, d, v);
    n_vec++;
    if (d !== 32'h1) begin
      n_miss++;
      $display("FAIL edge_set_wins: data=%h want 00000001", d);
    end
    bus_write(3'd2, 32'h1);
    bus_read(3'd2, d, v);
    n_vec++;
    if (d !== 32'h0) begin
      n_miss++;
      $display("FAIL edge_clear_late: data=%h want 00000000", d);
    end
    key_n_in = 4'hF;
    repeat (8) tick();
  endtask

  task automatic test_outputs();
    logic [31:0] d;
    logic        v;
    bus_write(3'd3, 32'hFFFF_F3FF);
    n_vec++;
    if (ledr_out !== 10'h3FF) begin
      n_miss++;
      $display("FAIL ledr_pin: ledr=%h want 3ff", ledr_out);
    end
    bus_read(3'd3, d, v);
    n_vec++;
    if (d !== 32'h3FF) begin
      n_miss++;
      $display("FAIL ledr_read: data=%h want 000003ff", d);
    end
    bus_write(3'd4, 32'h1234_5678);
    bus_write(3'd5, 32'hABCD_1234);
    n_vec++;
    if (hex3_hex0_out !== 32'h1234_5678 || hex5_hex4_out !== 16'h1234) begin
      n_miss++;
      $display("FAIL hex_pins: hex30=%h hex54=%h want 12345678 1234", hex3_hex0_out, hex5_hex4_out);
    end
    bus_read(3'd5, d, v);
    n_vec++;
    if (d !== 32'h0000_1234) begin
      n_miss++;
      $display("FAIL hex54_read: data=%h want 00001234", d);
    end
    bus_write(3'd7, 32'hFFFF_FFFF);
    bus_read(3'd7, d, v);
    n_vec++;
    if (d !== 32'h0) begin
      n_miss++;
      $display("FAIL reserved_read: data=%h want 00000000", d);
    end
  endtask

  task automatic test_back_to_back();
    avs.read    = 1'b1;
    avs.address = 3'd3;
    tick();
    n_vec++;
    if (avs.readdatavalid !== 1'b1 || avs.readdata !== 32'h3FF) begin
      n_miss++;
      $display("FAIL b2b_first: valid=%b data=%h want 1 000003ff", avs.readdatavalid, avs.readdata);
    end
    avs.address = 3'd4;
    tick();
    n_vec++;
    if (avs.readdatavalid !== 1'b1 || avs.readdata !== 32'h1234_5678) begin
      n_miss++;
      $display("FAIL b2b_second: valid=%b data=%h want 1 12345678", avs.readdatavalid, avs.readdata);
    end
    avs.read = 1'b0;
    tick();
    n_vec++;
    if (avs.readdatavalid !== 1'b0) begin
      n_miss++;
      $display("FAIL b2b_end: valid=%b want 0", avs.readdatavalid);
    end
  endtask

  task automatic test_rw_same_cycle();
    logic [31:0] d;
    logic        v;
    avs.address   = 3'd3;
    avs.writedata = 32'h155;
    avs.read      = 1'b1;
    avs.write     = 1'b1;
    tick();
    avs.read  = 1'b0;
    avs.write = 1'b0;
    n_vec++;
    if (avs.readdata !== 32'h3FF || ledr_out !== 10'h155) begin
      n_miss++;
      $display("FAIL rw_old_value: data=%h ledr=%h want 000003ff 155", avs.readdata, ledr_out);
    end
    bus_read(3'd3, d, v);
    n_vec++;
    if (d !== 32'h155) begin
      n_miss++;
      $display("FAIL rw_new_value: data=%h want 00000155", d);
    end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    logic        v;
    bus_write(3'd6, 32'h1);
    bus_read(3'd6, d, v);
`ifdef AVMM_IO_IRQ_EN
    n_vec++;
    if (d !== 32'h1) begin
      n_miss++;
      $display("FAIL irqmask_read: data=%h want 00000001", d);
    end
    key_n_in = 4'b1011;
    repeat (9) tick();
    n_vec++;
    if (irq !== 1'b0) begin
      n_miss++;
      $display("FAIL irq_masked: irq=%b want 0", irq);
    end
    bus_write(3'd2, 32'h4);
    key_n_in = 4'b1110;
    repeat (9) tick();
    n_vec++;
    if (irq !== 1'b1) begin
      n_miss++;
      $display("FAIL irq_set: irq=%b want 1", irq);
    end
    bus_write(3'd2, 32'h1);
    tick();
    n_vec++;
    if (irq !== 1'b0) begin
      n_miss++;
      $display("FAIL irq_clear: irq=%b want 0", irq);
    end
`else
    n_vec++;
    if (d !== 32'h0) begin
      n_miss++;
      $display("FAIL irqmask_absent: data=%h want 00000000", d);
    end
    key_n_in = 4'b1110;
    repeat (9) tick();
    n_vec++;
    if (irq !== 1'b0) begin
      n_miss++;
      $display("FAIL irq_tied: irq=%b want 0", irq);
    end
`endif
    key_n_in = 4'hF;
    repeat (8) tick();
  endtask

  initial begin
    rst_n         = 1'b0;
    sw_in         = '0;
    key_n_in      = 4'hF;
    avs.address   = '0;
    avs.read      = 1'b0;
    avs.write     = 1'b0;
    avs.writedata = '0;
    test_reset();
    test_switches();
    test_key_edge();
    test_edge_race();
    test_outputs();
    test_back_to_back();
    test_rw_same_cycle();
    test_irq();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
